key_event_ctrl: RTL

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_event_pkg.sv | 20 ++
 rtl/key_event_ch.sv | 118 +++++++++++
 rtl/key_event_ctrl.sv | 68 ++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// Shared types and default timing constants for the key event controller.
package key_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } key_st_e;

    localparam int DEF_TICK_CYCLES  = 500_000;
    localparam int DEF_LONG_TICKS   = 100;
    localparam int DEF_REPEAT_TICKS = 20;

    // Counter width able to hold 0..max_val (never narrower than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_event_ch.sv
// One debounced key channel: 4-state FSM stepped by the shared tick, hold/repeat counters, registered pulses.
// Auto-repeat after long press is built only when KEY_EVENT_REPEAT_EN is defined.
module key_event_ch
    import key_event_pkg::*;
#(
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_low,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int HW = cnt_width(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

    key_st_e       state, state_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic          press_nxt, rel_nxt, long_nxt;

`ifdef KEY_EVENT_REPEAT_EN
    localparam int RW = cnt_width(REPEAT_TICKS);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0] rep, rep_nxt;
`endif

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        long_nxt  = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
        rep_nxt   = rep;
`endif
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (key_low) state_nxt = ST_PRESS_CHK;
                end
                ST_PRESS_CHK: begin
                    if (key_low) begin
                        state_nxt = ST_HELD;
                        hold_nxt  = '0;
                        press_nxt = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
                        rep_nxt   = '0;
`endif
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (!key_low) begin
                        state_nxt = ST_REL_CHK;
                    end else if (hold != HOLD_MAX) begin
                        hold_nxt = hold + HW'(1);
                        long_nxt = (hold == HOLD_LAST);
                    end else begin
`ifdef KEY_EVENT_REPEAT_EN
                        // Saturated hold: repeat presses every REPEAT_TICKS ticks.
                        if (rep == REP_LAST) begin
                            rep_nxt   = '0;
                            press_nxt = 1'b1;
                        end else begin
                            rep_nxt = rep + RW'(1);
                        end
`endif
                    end
                end
                ST_REL_CHK: begin
                    if (!key_low) begin
                        state_nxt = ST_IDLE;
                        rel_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_HELD;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            hold        <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold        <= hold_nxt;
            key_press   <= press_nxt;
            key_release <= rel_nxt;
            key_long    <= long_nxt;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep <= '0;
        else     rep <= rep_nxt;
    end
`endif

    assign key_state = (state == ST_HELD) || (state == ST_REL_CHK);

    param_ok: assert property (@(posedge clk) disable iff (rst)
        (LONG_TICKS >= 2) && (REPEAT_TICKS >= 1));

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key debouncer: 2-flop input sync, shared sample tick, per-key event channels, toggling active-low LEDs.
// Optional auto-repeat of key_press after long press via KEY_EVENT_REPEAT_EN.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] led
);

    localparam int TW = cnt_width(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync_q1, sync_q2;
    logic [TW-1:0]       tick_cnt;
    logic                tick;

    // Idle-high reset value keeps a released key from looking pressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_event_ch #(
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .key_low     (~sync_q2[i]),
            .key_state   (key_state[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) led <= '1;
        else     led <= led ^ key_press;
    end

endmodule
